// File: rtl/torecfn_pkg.sv
// torecfn_pkg: shared definitions for the IEEE-to-recoded float pipeline.
//   - one-hot class bit positions for the {nan, inf, zero, normal, subnormal} vector
//   - 3-bit recoded exponent tags placed in the top bits of the exponent
//   - bias_rec(): the recoded exponent bias for a given IEEE exponent width
package torecfn_pkg;

  localparam int CLS_W    = 5;
  localparam int CLS_SUB  = 0;
  localparam int CLS_NORM = 1;
  localparam int CLS_ZERO = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_NAN  = 4;

  localparam logic [2:0] TAG_ZERO = 3'b000;
  localparam logic [2:0] TAG_INF  = 3'b110;
  localparam logic [2:0] TAG_NAN  = 3'b111;

  function automatic int bias_rec(input int exp_bits);
    return (1 << (exp_bits - 1)) + 1;
  endfunction

endpackage

// File: rtl/torecfn_pipe_lzd.sv
// torecfn_pipe_lzd: leading-zero counter.
// Ports:
//   data_i  [WIDTH-1:0]  value to scan from the MSB down
//   cnt_o   [CNT_W-1:0]  number of leading zeros (WIDTH when data_i is zero)
module torecfn_pipe_lzd #(
  parameter  int WIDTH = 23,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Ascending scan: the highest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/torecfn_pipe.sv
// torecfn_pipe: two-stage valid/ready pipeline converting an IEEE binary
// float into recoded form (extended exponent, explicit leading significand bit).
// Stage 1 classifies the operand and counts fraction leading zeros;
// stage 2 builds the recoded exponent/significand and holds the output.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           input handshake
//   in_fp [FP_BITS]             IEEE operand {sign, exp, fra}
//   in_canon                    replace NaN payload/sign with canonical NaN
//   out_valid/out_ready         output handshake
//   out_sign, out_exp, out_sig  recoded value
//   out_cls [5]                 one-hot {nan, inf, zero, normal, subnormal}
//   out_snan                    input was a signaling NaN
module torecfn_pipe
  import torecfn_pkg::*;
#(
  parameter  int EXP_BITS    = 8,
  parameter  int FRA_BITS    = 23,
  localparam int FP_BITS     = 1 + EXP_BITS + FRA_BITS,
  localparam int EXPREC_BITS = EXP_BITS + 1,
  localparam int SIG_BITS    = FRA_BITS + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FP_BITS-1:0]     in_fp,
  input  logic                   in_canon,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXPREC_BITS-1:0] out_exp,
  output logic [SIG_BITS-1:0]    out_sig,
  output logic [CLS_W-1:0]       out_cls,
  output logic                   out_snan
);

  localparam int BIAS_REC = bias_rec(EXP_BITS);
  localparam int LZ_W     = $clog2(FRA_BITS + 1);

  localparam logic [EXPREC_BITS-1:0] EXP_ZERO = {TAG_ZERO, {(EXPREC_BITS-3){1'b0}}};
  localparam logic [EXPREC_BITS-1:0] EXP_INF  = {TAG_INF,  {(EXPREC_BITS-3){1'b0}}};
  localparam logic [EXPREC_BITS-1:0] EXP_NAN  = {TAG_NAN,  {(EXPREC_BITS-3){1'b0}}};
  localparam logic [SIG_BITS-1:0]    SIG_QNAN = {2'b11, {(SIG_BITS-2){1'b0}}};

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, accept;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;
  assign out_valid = s2_valid_q;

  // Stage 1 decode
  logic                sign_in;
  logic [EXP_BITS-1:0] exp_in;
  logic [FRA_BITS-1:0] fra_in;
  logic [CLS_W-1:0]    cls_in;
  logic [LZ_W-1:0]     lz_in;

  assign sign_in = in_fp[FP_BITS-1];
  assign exp_in  = in_fp[FP_BITS-2 -: EXP_BITS];
  assign fra_in  = in_fp[FRA_BITS-1:0];

  always_comb begin
    cls_in = '0;
    if (exp_in == '0) begin
      if (fra_in == '0) cls_in[CLS_ZERO] = 1'b1;
      else              cls_in[CLS_SUB]  = 1'b1;
    end else if (&exp_in) begin
      if (fra_in == '0) cls_in[CLS_INF]  = 1'b1;
      else              cls_in[CLS_NAN]  = 1'b1;
    end else begin
      cls_in[CLS_NORM] = 1'b1;
    end
  end

  torecfn_pipe_lzd #(.WIDTH(FRA_BITS)) u_lzd (
    .data_i (fra_in),
    .cnt_o  (lz_in)
  );

  logic                s1_sign_q, s1_canon_q;
  logic [EXP_BITS-1:0] s1_exp_q;
  logic [FRA_BITS-1:0] s1_fra_q;
  logic [CLS_W-1:0]    s1_cls_q;
  logic [LZ_W-1:0]     s1_lz_q;

  // Data registers load only on acceptance so idle-cycle inputs never reach the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_canon_q <= 1'b0;
      s1_exp_q   <= '0;
      s1_fra_q   <= '0;
      s1_cls_q   <= '0;
      s1_lz_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sign_q  <= sign_in;
        s1_canon_q <= in_canon;
        s1_exp_q   <= exp_in;
        s1_fra_q   <= fra_in;
        s1_cls_q   <= cls_in;
        s1_lz_q    <= lz_in;
      end
    end
  end

  // Stage 2 encode
  logic                   sign_d, snan_d;
  logic [EXPREC_BITS-1:0] exp_d;
  logic [SIG_BITS-1:0]    sig_d;
  logic [FRA_BITS-1:0]    fra_norm, fra_sub;

  // Subnormal normalisation: shift the leading one out past the top, it becomes
  // the explicit significand bit.
  assign fra_norm = s1_fra_q << s1_lz_q;
  assign fra_sub  = fra_norm << 1;

  always_comb begin
    sign_d = s1_sign_q;
    snan_d = 1'b0;
    exp_d  = EXP_ZERO;
    sig_d  = '0;
    if (s1_cls_q[CLS_NORM]) begin
      exp_d = {1'b0, s1_exp_q} + EXPREC_BITS'(BIAS_REC);
      sig_d = {1'b1, s1_fra_q};
    end else if (s1_cls_q[CLS_SUB]) begin
      // Wraps modulo 2^EXPREC_BITS for deep subnormals.
      exp_d = EXPREC_BITS'(BIAS_REC) - EXPREC_BITS'(s1_lz_q);
      sig_d = {1'b1, fra_sub};
    end else if (s1_cls_q[CLS_INF]) begin
      exp_d = EXP_INF;
    end else if (s1_cls_q[CLS_NAN]) begin
      exp_d  = EXP_NAN;
      snan_d = !s1_fra_q[FRA_BITS-1];
      if (s1_canon_q) begin
        sign_d = 1'b0;
        sig_d  = SIG_QNAN;
      end else begin
        sig_d  = {1'b1, s1_fra_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_sig    <= '0;
      out_cls    <= '0;
      out_snan   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign <= sign_d;
        out_exp  <= exp_d;
        out_sig  <= sig_d;
        out_cls  <= s1_cls_q;
        out_snan <= snan_d;
      end
    end
  end

endmodule

// File: tb/tb_torecfn_pipe.sv
module tb_torecfn_pipe;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] sig;
    logic [4:0]  cls;
    logic        snan;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_canon;
  logic [31:0] in_fp;
  logic        out_valid, out_ready, out_sign, out_snan;
  logic [8:0]  out_exp;
  logic [23:0] out_sig;
  logic [4:0]  out_cls;

  logic        h_in_valid, h_in_ready, h_in_canon;
  logic [15:0] h_in_fp;
  logic        h_out_valid, h_out_ready, h_out_sign, h_out_snan;
  logic [5:0]  h_out_exp;
  logic [10:0] h_out_sig;
  logic [4:0]  h_out_cls;

  torecfn_pipe #(.EXP_BITS(8), .FRA_BITS(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp), .in_canon(in_canon),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_sig(out_sig), .out_cls(out_cls), .out_snan(out_snan)
  );

  torecfn_pipe #(.EXP_BITS(5), .FRA_BITS(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_fp(h_in_fp), .in_canon(h_in_canon),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sign(h_out_sign),
    .out_exp(h_out_exp), .out_sig(h_out_sig), .out_cls(h_out_cls), .out_snan(h_out_snan)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: recoded value of an FP32 operand, from the value-level rules.
  // Subnormals are normalised by shifting until the hidden-bit position is
  // occupied; each shift beyond the first lowers the exponent by one.
  function automatic res_t model(input logic [31:0] fp, input logic canon);
    res_t r;
    int e, n;
    logic [22:0] f;
    logic [23:0] m;
    r = '0;
    r.sign = fp[31];
    e = int'(fp[30:23]);
    f = fp[22:0];
    if (e == 0 && f == 0) begin
      r.cls = 5'b00100;
    end else if (e == 0) begin
      m = {1'b0, f};
      n = 0;
      while (!m[23]) begin
        m = m << 1;
        n++;
      end
      r.exp = 9'(129 - (n - 1));
      r.sig = m;
      r.cls = 5'b00001;
    end else if (e == 255 && f == 0) begin
      r.exp = 9'h180;
      r.cls = 5'b01000;
    end else if (e == 255) begin
      r.exp  = 9'h1C0;
      r.cls  = 5'b10000;
      r.snan = !f[22];
      if (canon) begin
        r.sign = 1'b0;
        r.sig  = 24'hC00000;
      end else begin
        r.sig  = {1'b1, f};
      end
    end else begin
      r.exp = 9'(e + 129);
      r.sig = {1'b1, f};
      r.cls = 5'b00010;
    end
    return r;
  endfunction

  // Scoreboard and per-cycle compare process.
  res_t exp_q[$];
  res_t cur, held, want_front;
  bit   held_v = 1'b0;

  always @(negedge clk) begin
    cur = {out_sign, out_exp, out_sig, out_cls, out_snan};
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_bundle", cur, held);
      end
      // Two operands in flight fill both stages; only then may a stall block input.
      chk("in_ready_occ", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none", cur);
        end else begin
          want_front = exp_q.pop_front();
          chk("stream_out", cur, want_front);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_fp, in_canon));
      held_v = out_valid && !out_ready;
      held   = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [31:0] fp, input logic canon, input res_t want);
    int n;
    res_t got;
    chk({nm, "_model"}, model(fp, canon), want);
    out_ready = 1'b1;
    n = 0;
    while ((!in_ready || out_valid) && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_fp    = fp;
    in_canon = canon;
    tick();
    in_valid = 1'b0;
    in_fp    = 'x;
    in_canon = 1'bx;
    chk({nm, "_lat1"}, out_valid, 1'b0);
    tick();
    chk({nm, "_lat2"}, out_valid, 1'b1);
    got = {out_sign, out_exp, out_sig, out_cls, out_snan};
    chk({nm, "_sign"}, got.sign, want.sign);
    chk({nm, "_exp"},  got.exp,  want.exp);
    chk({nm, "_sig"},  got.sig,  want.sig);
    chk({nm, "_cls"},  got.cls,  want.cls);
    chk({nm, "_snan"}, got.snan, want.snan);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int sel;
    sel = $urandom_range(0, 7);
    f = 23'($urandom());
    case (sel)
      0: begin e = 8'h00; f = '0; end
      1: begin
        e = 8'h00;
        f = f >> $urandom_range(0, 22);
        if (f == 0) f = 23'd1;
      end
      2: begin e = 8'hFF; f = '0; end
      3: begin e = 8'hFF; if (f == 0) f = 23'd1; end
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  task automatic stream(input int count, input bit gaps);
    int n;
    for (int k = 0; k < count; k++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid  = 1'b1;
      in_fp     = rand_fp();
      in_canon  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
        n++;
        @(negedge clk);
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=stalled required=in_ready");
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_fp = '0; in_canon = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_fp = '0; h_in_canon = 1'b0; h_out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bundle", {out_sign, out_exp, out_sig, out_cls, out_snan}, 40'd0);
    rst_n = 1'b1;
    tick();

    directed("one",      32'h3F800000, 1'b0, '{1'b0, 9'h100, 24'h800000, 5'b00010, 1'b0});
    directed("sub_min",  32'h00000001, 1'b0, '{1'b0, 9'h06B, 24'h800000, 5'b00001, 1'b0});
    directed("sub_top",  32'h00400000, 1'b0, '{1'b0, 9'h081, 24'h800000, 5'b00001, 1'b0});
    directed("inf",      32'h7F800000, 1'b0, '{1'b0, 9'h180, 24'h000000, 5'b01000, 1'b0});
    directed("negzero",  32'h80000000, 1'b0, '{1'b1, 9'h000, 24'h000000, 5'b00100, 1'b0});
    directed("snan_can", 32'hFF800001, 1'b1, '{1'b0, 9'h1C0, 24'hC00000, 5'b10000, 1'b1});
    directed("qnan",     32'h7FC00001, 1'b0, '{1'b0, 9'h1C0, 24'hC00001, 5'b10000, 1'b0});
    directed("maxnorm",  32'h7F7FFFFF, 1'b0, '{1'b0, 9'h17F, 24'hFFFFFF, 5'b00010, 1'b0});
    directed("canon_nn", 32'hBF800000, 1'b1, '{1'b1, 9'h100, 24'h800000, 5'b00010, 1'b0});

    // Ten back-to-back operands under random backpressure, then a gappy run.
    stream(10, 1'b0);
    drain("drain_b2b");
    stream(300, 1'b1);
    drain("drain_rand");

    // Reset with both stages occupied.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_fp = 32'h40490FDB; in_canon = 1'b0;
    tick();
    in_fp = 32'h00000001;
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_in_ready", in_ready, 1'b1);
    chk("async_bundle", {out_sign, out_exp, out_sig, out_cls, out_snan}, 40'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    directed("post_rst", 32'hC0200000, 1'b0, '{1'b1, 9'h101, 24'hA00000, 5'b00010, 1'b0});
    drain("drain_rst");

    // Half-precision build.
    tick();
    h_in_valid = 1'b1; h_in_fp = 16'h0001;
    tick();
    h_in_fp = 16'h3C00;
    tick();
    h_in_valid = 1'b0;
    chk("h_sub_valid", h_out_valid, 1'b1);
    chk("h_sub_exp", h_out_exp, 6'h08);
    chk("h_sub_sig", h_out_sig, 11'h400);
    chk("h_sub_cls", h_out_cls, 5'b00001);
    tick();
    chk("h_one_valid", h_out_valid, 1'b1);
    chk("h_one_exp", h_out_exp, 6'h20);
    chk("h_one_sig", h_out_sig, 11'h400);
    chk("h_one_cls", h_out_cls, 5'b00010);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/torecfn_pipe.md
TORECFN_PIPE -- requirements
Module: torecfn_pipe

Interface
REQ-001 SHALL have parameter EXP_BITS, default 8, meaning the IEEE exponent width (legal values 5..11).
REQ-002 SHALL have parameter FRA_BITS, default 23, meaning the IEEE fraction width (legal values 10..52).
REQ-003 SHALL derive FP_BITS=1+EXP_BITS+FRA_BITS, EXPREC_BITS=EXP_BITS+1, SIG_BITS=FRA_BITS+1, and BIAS_REC=2^(EXP_BITS-1)+1 as localparams.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning in_fp and in_canon are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-008 SHALL have port in_fp, input, FP_BITS, the IEEE operand {sign, exp, fra}.
REQ-009 SHALL have port in_canon, input, 1, which requests canonical-NaN output for this operand.
REQ-010 SHALL have port out_valid, output, 1, meaning the output bundle is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream consumer accepts the output.
REQ-012 SHALL have port out_sign, output, 1, the sign.
REQ-013 SHALL have port out_exp, output, EXPREC_BITS, the recoded exponent.
REQ-014 SHALL have port out_sig, output, SIG_BITS, the significand with explicit leading bit.
REQ-015 SHALL have port out_cls, output, 5, a one-hot class vector {nan, inf, zero, normal, subnormal}.
REQ-016 SHALL have port out_snan, output, 1, meaning the input was a signaling NaN (invalid flag).

Function
REQ-017 SHALL classify the operand as follows: exp==0 with fra==0 is zero; exp==0 with fra!=0 is subnormal; exp all-ones with fra==0 is inf; exp all-ones with fra!=0 is NaN; any other value is normal.
REQ-018 SHALL encode a normal operand as out_exp={1'b0,exp}+BIAS_REC and out_sig={1,fra}.
REQ-019 SHALL encode a subnormal operand using lz = leading zeros of fra (0..FRA_BITS-1): out_exp=BIAS_REC-lz (mod 2^EXPREC_BITS) and out_sig={1,(fra<<(lz+1))[FRA_BITS-1:0]}.
REQ-020 SHALL encode zero as out_exp=0 and out_sig=0.
REQ-021 SHALL encode inf as out_exp={3'b110,0...} and out_sig=0.
REQ-022 SHALL encode NaN as out_exp={3'b111,0...} and out_sig={1,fra}.
REQ-023 SHALL set out_snan=1 when the input is a NaN with fra MSB=0; it is 0 otherwise.
REQ-024 SHALL, for a NaN accepted with in_canon=1, output out_sign=0 and out_sig={2'b11,0...}; out_snan still reflects the input.
REQ-025 SHALL use a two-stage pipeline: S1 registers the class, lz and fields; S2 registers the encoded output; latency is exactly 2 cycles from acceptance to out_valid when there is no stall.
REQ-026 SHALL accept an input only when in_valid && in_ready, and SHALL transfer an output only when out_valid && out_ready.
REQ-027 SHALL advance S2 when !s2_valid || out_ready, SHALL advance S1 when !s1_valid || S2 advances, and SHALL drive in_ready equal to the S1-advance condition.
REQ-028 SHALL sustain full throughput of 1 operand/cycle while out_ready=1.
REQ-029 SHALL hold the output bundle stable while out_valid && !out_ready.
REQ-030 SHALL, when a stage is full and downstream is stalled, hold that stage and SHALL neither drop nor duplicate any operand.
REQ-031 SHALL ignore in_fp and in_canon when in_valid=0, including X values on those ports.

Reset
REQ-032 SHALL, while rst_n=0, immediately clear both stage valid bits, with out_valid=0 and in_ready=1.
REQ-033 SHALL reset out_sign, out_exp, out_sig, out_cls and out_snan to 0.
REQ-034 SHALL discard any in-flight operand on reset mid-operation, and the first output after reset SHALL be the first operand accepted after reset.

Structure
REQ-035 SHALL place the class one-hot bit indices, the recoded special tags (000/110/111) and a BIAS_REC function in shared package torecfn_pkg.
REQ-036 SHALL instantiate leading-zero counting as a sub-module LZD, parameterised by input width, with output width $clog2(FRA_BITS+1).

Verification
REQ-037 SHALL verify: FP32 0x3F800000 -> out_exp=0x100, out_sig=0x800000, cls=normal, at cycle 2.
REQ-038 SHALL verify: FP32 0x00000001 -> out_exp=0x06B, out_sig=0x800000, cls=subnormal; 0x00400000 -> out_exp=0x081, out_sig=0x800000.
REQ-039 SHALL verify: 0x7F800000 -> out_exp=0x180, out_sig=0; 0x80000000 -> out_sign=1, out_exp=0, out_sig=0.
REQ-040 SHALL verify: 0xFF800001 with in_canon=1 -> out_sign=0, out_exp=0x1C0, out_sig=0xC00000, out_snan=1; 0x7FC00001 with in_canon=0 -> out_sig=0xC00001, out_snan=0.
REQ-041 SHALL verify: 10 back-to-back operands with out_ready toggling randomly -> in-order delivery with no loss, and in_ready=0 only when both stages are full and stalled.
REQ-042 SHALL verify: rst_n pulsed low with 2 operands in flight -> out_valid=0 asynchronously, and the next output equals the first operand accepted after reset; also run a FP16 build (5,10) where 0x0001 -> out_exp=0x008.
